// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the UART parity engine: parity mode
//             encodings and the engine state type.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Parity mode encodings as presented on in_mode; unlisted codes mean none.
  localparam logic [2:0] PAR_NONE  = 3'b000;
  localparam logic [2:0] PAR_ODD   = 3'b001;
  localparam logic [2:0] PAR_EVEN  = 3'b010;
  localparam logic [2:0] PAR_MARK  = 3'b011;
  localparam logic [2:0] PAR_SPACE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_err_counter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_err_counter
//  Purpose  : Saturating event counter. Clear wins over increment in the
//             same cycle; the count sticks at all-ones.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             inc           - count one event this cycle
//             clr           - synchronous clear
//             count         - current count
//  Revision : 1.0 - initial release
// ============================================================================
module uart_err_counter #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [ERR_CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {ERR_CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_parity_engine.sv
`default_nettype none
// ============================================================================
//  Module   : uart_parity_engine
//  Purpose  : Serial parity generator/checker. Folds one data bit per clock,
//             LSB first, then presents the parity bit for the selected mode
//             and, in check mode, a mismatch flag plus a saturating count.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             in_valid/in_ready             - request handshake
//             in_data, in_len, in_mode      - word, bit count, parity mode
//             in_chk, in_rx_par             - check enable, received parity
//             out_valid/out_ready           - result handshake
//             out_parity, out_none, out_err - registered result
//             err_count, clr_count          - mismatch counter and its clear
//  Revision : 1.0 - initial release
// ============================================================================
module uart_parity_engine
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [LEN_W-1:0]     in_len,
  input  logic [2:0]           in_mode,
  input  logic                 in_chk,
  input  logic                 in_rx_par,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_parity,
  output logic                 out_none,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_count
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  cnt;
  logic [2:0]        mode_r;
  logic              chk_r;
  logic              rx_par_r;
  logic              acc;

  logic [LEN_W-1:0]  len_res;
  logic              par_calc;
  logic              none_calc;

  // Zero or over-long lengths fall back to the full word.
  always_comb begin
    len_res = in_len;
    if ((in_len == '0) || (in_len > MAX_LEN)) begin
      len_res = MAX_LEN;
    end
  end

  always_comb begin
    par_calc  = 1'b0;
    none_calc = 1'b0;
    case (mode_r)
      PAR_ODD:   par_calc = ~acc;
      PAR_EVEN:  par_calc = acc;
      PAR_MARK:  par_calc = 1'b1;
      PAR_SPACE: par_calc = 1'b0;
      default:   none_calc = 1'b1;
    endcase
  end

  assign in_ready = (state == ST_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      len_r      <= '0;
      cnt        <= '0;
      mode_r     <= PAR_NONE;
      chk_r      <= 1'b0;
      rx_par_r   <= 1'b0;
      acc        <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= 1'b0;
      out_none   <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg    <= in_data;
            len_r    <= len_res;
            mode_r   <= in_mode;
            chk_r    <= in_chk;
            rx_par_r <= in_rx_par;
            acc      <= 1'b0;
            cnt      <= '0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The word is shifted down so the next bit to fold is always bit 0.
          acc   <= acc ^ shreg[0];
          shreg <= shreg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == len_r - 1'b1) begin
            state <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          // First RESULT cycle registers the outputs; they then hold until
          // the consumer takes them.
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_parity <= par_calc;
            out_none   <= none_calc;
            out_err    <= chk_r && !none_calc && (rx_par_r != par_calc);
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_err_counter #(
    .ERR_CNT_W (ERR_CNT_W)
  ) u_err_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && out_ready && out_err),
    .clr   (clr_count),
    .count (err_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_parity_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_parity_engine
//  Purpose  : Self-checking bench for uart_parity_engine with a behavioural
//             parity model (counts ones) and a saturating error-count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_parity_engine;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [LW-1:0] in_len = '0;
  logic [2:0]    in_mode = '0;
  logic          in_chk = 1'b0;
  logic          in_rx_par = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_parity;
  logic          out_none;
  logic          out_err;
  logic [CW-1:0] err_count;
  logic          clr_count = 1'b0;

  int checks = 0;
  int failures = 0;
  int em = 0;   // modelled err_count

  always #5 clk = ~clk;

  uart_parity_engine #(.DATA_W(DW), .LEN_W(LW), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .in_mode(in_mode), .in_chk(in_chk),
    .in_rx_par(in_rx_par), .out_valid(out_valid), .out_ready(out_ready),
    .out_parity(out_parity), .out_none(out_none), .out_err(out_err),
    .err_count(err_count), .clr_count(clr_count)
  );

  // Reference: parity from a count of ones over the effective length.
  function automatic void model(input logic [DW-1:0] d, input int len,
                                input logic [2:0] mode, input bit chk, input bit rx,
                                output bit par, output bit none, output bit err,
                                output int lat);
    int l;
    int ones;
    l = (len == 0 || len > DW) ? DW : len;
    ones = 0;
    for (int i = 0; i < l; i++) ones += (int'(d) >> i) % 2;
    none = 1'b0;
    case (mode)
      3'd1: par = (ones % 2 == 0);
      3'd2: par = (ones % 2 == 1);
      3'd3: par = 1'b1;
      3'd4: par = 1'b0;
      default: begin par = 1'b0; none = 1'b1; end
    endcase
    err = chk && !none && (rx != par);
    lat = l + 1;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a word, then count edges from acceptance to out_valid.
  task automatic issue(input logic [DW-1:0] d, input logic [LW-1:0] len,
                       input logic [2:0] mode, input bit chk, input bit rx,
                       output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout in_ready=%0b required=1", in_ready);
    end
    in_data = d; in_len = len; in_mode = mode; in_chk = chk; in_rx_par = rx;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Inputs changing after acceptance must not disturb the word in flight.
    in_data = DW'($urandom); in_len = LW'($urandom); in_mode = 3'($urandom);
    in_chk = 1'($urandom); in_rx_par = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL result_timeout out_valid=%0b required=1", out_valid);
    end
  endtask

  task automatic handshake(input bit clr, input bit exp_err);
    out_ready = 1'b1; clr_count = clr;
    tick();
    out_ready = 1'b0; clr_count = 1'b0;
    if (clr) em = 0;
    else if (exp_err) em = sat_inc(em);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({out_valid, out_parity, out_none, out_err, in_ready} !== 5'b0 || err_count !== '0) begin
      failures++;
      $display("FAIL reset_state v=%0b p=%0b n=%0b e=%0b rdy=%0b cnt=%0d required all 0",
               out_valid, out_parity, out_none, out_err, in_ready, err_count);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready in_ready=%0b required=1", in_ready);
    end
    em = 0;
  endtask

  task automatic test_modes();
    logic [DW-1:0] td [8] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    logic [LW-1:0] tl [8] = '{4'd8, 4'd8, 4'd7, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8};
    logic [2:0]    tm [8] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd7};
    bit            tp [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit            tn [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      issue(td[i], tl[i], tm[i], 1'b0, 1'b0, lat);
      checks++;
      if (out_parity !== tp[i] || out_none !== tn[i] || out_err !== 1'b0) begin
        failures++;
        $display("FAIL mode_table[%0d] par=%0b none=%0b err=%0b required par=%0b none=%0b err=0",
                 i, out_parity, out_none, out_err, tp[i], tn[i]);
      end
      handshake(1'b0, 1'b0);
    end
  endtask

  task automatic test_latency();
    logic [LW-1:0] ll [5] = '{4'd8, 4'd5, 4'd0, 4'd12, 4'd1};
    int            le [5] = '{9, 6, 9, 9, 2};
    int lat;
    for (int i = 0; i < 5; i++) begin
      issue(8'h3C, ll[i], 3'd2, 1'b0, 1'b0, lat);
      checks++;
      if (lat !== le[i]) begin
        failures++;
        $display("FAIL latency len=%0d cycles=%0d required=%0d", ll[i], lat, le[i]);
      end
      handshake(1'b0, 1'b0);
    end
  endtask

  task automatic test_check();
    bit cc [3] = '{1'b1, 1'b1, 1'b0};
    bit cr [3] = '{1'b0, 1'b1, 1'b0};
    bit ce [3] = '{1'b1, 1'b0, 1'b0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(8'h01, 4'd8, 3'd2, cc[i], cr[i], lat);
      checks++;
      if (out_err !== ce[i] || out_parity !== 1'b1) begin
        failures++;
        $display("FAIL check_err[%0d] err=%0b par=%0b required err=%0b par=1",
                 i, out_err, out_parity, ce[i]);
      end
      handshake(1'b0, ce[i]);
      checks++;
      if (int'(err_count) !== em) begin
        failures++;
        $display("FAIL check_count[%0d] err_count=%0d required=%0d", i, err_count, em);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(8'h01, 4'd8, 3'd2, 1'b1, 1'b0, lat);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_parity !== 1'b1 || out_err !== 1'b1 ||
          in_ready !== 1'b0 || int'(err_count) !== em) begin
        failures++;
        $display("FAIL backpressure_hold[%0d] v=%0b p=%0b e=%0b rdy=%0b cnt=%0d required v=1 p=1 e=1 rdy=0 cnt=%0d",
                 i, out_valid, out_parity, out_err, in_ready, err_count, em);
      end
    end
    handshake(1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || int'(err_count) !== em) begin
      failures++;
      $display("FAIL backpressure_release v=%0b cnt=%0d required v=0 cnt=%0d",
               out_valid, err_count, em);
    end
  endtask

  task automatic test_saturation();
    int lat;
    clr_count = 1'b1; tick(); clr_count = 1'b0; em = 0;
    checks++;
    if (err_count !== '0) begin
      failures++;
      $display("FAIL clear_idle err_count=%0d required=0", err_count);
    end
    for (int i = 0; i < 300; i++) begin
      issue(8'h01, 4'd1, 3'd2, 1'b1, 1'b0, lat);
      handshake(1'b0, 1'b1);
    end
    checks++;
    if (int'(err_count) !== em || em !== 255) begin
      failures++;
      $display("FAIL saturation err_count=%0d required=%0d", err_count, 255);
    end
    issue(8'h01, 4'd1, 3'd2, 1'b1, 1'b0, lat);
    handshake(1'b1, 1'b1);
    checks++;
    if (err_count !== '0) begin
      failures++;
      $display("FAIL clear_priority err_count=%0d required=0", err_count);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    issue(8'h01, 4'd8, 3'd2, 1'b1, 1'b0, lat);
    handshake(1'b0, 1'b1);      // make err_count nonzero first
    in_data = 8'hFF; in_len = 4'd8; in_mode = 3'd1; in_chk = 1'b1; in_rx_par = 1'b0;
    in_valid = 1'b1;
    tick();                     // accepted
    in_valid = 1'b0;
    tick(); tick();             // two folds done, third SHIFT cycle now
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || err_count !== '0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid v=%0b cnt=%0d rdy=%0b required v=0 cnt=0 rdy=0",
               out_valid, err_count, in_ready);
    end
    rst = 1'b0; em = 0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_no_result seen_valid=%0b rdy=%0b required seen_valid=0 rdy=1",
               seen, in_ready);
    end
    issue(8'hA5, 4'd8, 3'd1, 1'b1, 1'b1, lat);
    checks++;
    if (out_parity !== 1'b1 || out_err !== 1'b0 || lat !== 9) begin
      failures++;
      $display("FAIL reset_mid_next par=%0b err=%0b lat=%0d required par=1 err=0 lat=9",
               out_parity, out_err, lat);
    end
    handshake(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [LW-1:0] l;
    logic [2:0]    m;
    bit c, r, clr, ep, en, ee;
    int lat, el;
    for (int i = 0; i < 60; i++) begin
      d = DW'($urandom); l = LW'($urandom); m = 3'($urandom);
      c = 1'($urandom); r = 1'($urandom); clr = ($urandom_range(0, 7) == 0);
      model(d, int'(l), m, c, r, ep, en, ee, el);
      issue(d, l, m, c, r, lat);
      checks++;
      if (out_parity !== ep || out_none !== en || out_err !== ee || lat !== el) begin
        failures++;
        $display("FAIL random[%0d] d=%h l=%0d m=%0d par=%0b none=%0b err=%0b lat=%0d required %0b %0b %0b %0d",
                 i, d, l, m, out_parity, out_none, out_err, lat, ep, en, ee, el);
      end
      handshake(clr, ee);
      checks++;
      if (int'(err_count) !== em) begin
        failures++;
        $display("FAIL random_count[%0d] err_count=%0d required=%0d", i, err_count, em);
      end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_latency();
    test_check();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
